mem_stage: RTL and testbench

- Memory-access stage, directly downstream of the execute stage. Consumes its EX/MEM register outputs.
- Resolves pc-relative and flag branches, and drives branch_taken / branch_target back to IF and EX.
- Performs data-memory loads and stores over a req/ack handshake with a timeout. Stalls the pipeline while waiting.
- Registers results into the MEM/WB pipeline register.

---
 rtl/mem_stage.sv | 133 +++++++++++++
 tb/tb_mem_stage.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage: branch resolve, dmem req/ack with timeout, MEM/WB register
module mem_stage #(
    parameter int          DATA_W     = 32,
    parameter int          PC_W       = 32,
    parameter int          RA_W       = 4,
    parameter int          TIMEOUT    = 15,
    parameter logic [1:0]  WB_MEM_SEL = 2'b01
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_write_enable,
    input  logic              sel_beq_bne,
    input  logic              sel_jt_jf,
    input  logic              is_branch,
    input  logic              sel_jflag_branch,
    input  logic [1:0]        wb_res_mux,
    input  logic              reg_write_enable,
    input  logic [RA_W-1:0]   reg_dest,
    input  logic [5:0]        flags,
    input  logic [RA_W-1:0]   flag_code,
    input  logic [PC_W-1:0]   branch_addr,
    input  logic [DATA_W-1:0] alu_res,
    input  logic [DATA_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [PC_W-1:0]   next_pc,
    input  logic [DATA_W-1:0] imm,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic              mem_stall,
    output logic              mem_err,
    output logic              branch_taken,
    output logic [PC_W-1:0]   branch_target,
    output logic [1:0]        out_wb_res_mux,
    output logic              out_reg_write_enable,
    output logic [RA_W-1:0]   out_reg_dest,
    output logic [DATA_W-1:0] out_alu_res,
    output logic [DATA_W-1:0] out_mem_rdata,
    output logic [PC_W-1:0]   out_next_pc,
    output logic [DATA_W-1:0] out_imm
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             load;
    logic             access;
    logic             timeout_hit;
    logic             abort;
    logic             load_done;
    logic [7:0]       flags_ext;
    logic             cond;

    assign load        = reg_write_enable & (wb_res_mux == WB_MEM_SEL);
    assign access      = mem_write_enable | load;
    assign timeout_hit = (state == ST_WAIT) && (count == CNT_W'(TIMEOUT));
    assign abort       = timeout_hit & ~dmem_ack;
    assign load_done   = dmem_req & dmem_ack & load & ~mem_write_enable;

    // Gating with rst lets a reset mid-wait drop the request even while EX/MEM still holds the access.
    assign dmem_req   = ~rst & ((state == ST_WAIT) | access);
    assign dmem_we    = mem_write_enable;
    assign dmem_addr  = mem_addr;
    assign dmem_wdata = mem_data;
    assign mem_stall  = dmem_req & ~dmem_ack & ~timeout_hit;

    assign flags_ext     = {2'b00, flags};
    assign cond          = sel_jflag_branch ? ((flag_code < RA_W'(6)) ? flags_ext[flag_code[2:0]] : 1'b0)
                                            : flags[0];
    assign branch_taken  = is_branch & (cond ^ (sel_jflag_branch ? sel_jt_jf : sel_beq_bne));
    assign branch_target = branch_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= ST_IDLE;
            count                <= '0;
            mem_err              <= 1'b0;
            out_wb_res_mux       <= '0;
            out_reg_write_enable <= 1'b0;
            out_reg_dest         <= '0;
            out_alu_res          <= '0;
            out_mem_rdata        <= '0;
            out_next_pc          <= '0;
            out_imm              <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (access && !dmem_ack) begin
                        state <= ST_WAIT;
                        count <= CNT_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (dmem_ack) begin
                        state <= ST_IDLE;
                        count <= '0;
                    end else if (count == CNT_W'(TIMEOUT)) begin
                        state   <= ST_IDLE;
                        count   <= '0;
                        mem_err <= 1'b1;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    count <= '0;
                end
            endcase

            if (mem_stall) begin
                out_reg_write_enable <= 1'b0;
                out_wb_res_mux       <= '0;
            end else begin
                // An aborted access must not reach the register file.
                out_reg_write_enable <= reg_write_enable & ~abort;
                out_wb_res_mux       <= wb_res_mux;
                out_reg_dest         <= reg_dest;
                out_alu_res          <= alu_res;
                out_next_pc          <= next_pc;
                out_imm              <= imm;
                if (load_done) begin
                    out_mem_rdata <= dmem_rdata;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage with a transaction-level reference model
module tb_mem_stage;
    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_write_enable, sel_beq_bne, sel_jt_jf, is_branch, sel_jflag_branch;
    logic [1:0]  wb_res_mux;
    logic        reg_write_enable;
    logic [3:0]  reg_dest, flag_code;
    logic [5:0]  flags;
    logic [31:0] branch_addr, alu_res, mem_addr, mem_data, next_pc, imm, dmem_rdata;
    logic        dmem_ack;
    logic        dmem_req, dmem_we, mem_stall, mem_err, branch_taken;
    logic [31:0] dmem_addr, dmem_wdata, branch_target;
    logic [1:0]  out_wb_res_mux;
    logic        out_reg_write_enable;
    logic [3:0]  out_reg_dest;
    logic [31:0] out_alu_res, out_mem_rdata, out_next_pc, out_imm;

    int          total = 0;
    int          bad = 0;
    int          writes = 0;
    logic [31:0] exp_rdata = 32'h0;
    logic        exp_err = 1'b0;

    mem_stage #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .mem_write_enable(mem_write_enable), .sel_beq_bne(sel_beq_bne),
        .sel_jt_jf(sel_jt_jf), .is_branch(is_branch), .sel_jflag_branch(sel_jflag_branch),
        .wb_res_mux(wb_res_mux), .reg_write_enable(reg_write_enable), .reg_dest(reg_dest),
        .flags(flags), .flag_code(flag_code), .branch_addr(branch_addr), .alu_res(alu_res),
        .mem_addr(mem_addr), .mem_data(mem_data), .next_pc(next_pc), .imm(imm),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .mem_stall(mem_stall), .mem_err(mem_err),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .out_wb_res_mux(out_wb_res_mux), .out_reg_write_enable(out_reg_write_enable),
        .out_reg_dest(out_reg_dest), .out_alu_res(out_alu_res), .out_mem_rdata(out_mem_rdata),
        .out_next_pc(out_next_pc), .out_imm(out_imm)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && dmem_req && dmem_ack && dmem_we) writes++;
    end

    task automatic clear_inputs();
        mem_write_enable = 0; sel_beq_bne = 0; sel_jt_jf = 0; is_branch = 0; sel_jflag_branch = 0;
        wb_res_mux = 0; reg_write_enable = 0; reg_dest = 0; flags = 0; flag_code = 0;
        branch_addr = 0; alu_res = 0; mem_addr = 0; mem_data = 0; next_pc = 0; imm = 0;
        dmem_ack = 0; dmem_rdata = 0;
    endtask

    // One memory instruction whose ack arrives lat cycles after it is presented (lat > TIMEOUT = never).
    task automatic run_access(input bit is_store, input int lat, input logic [31:0] rd);
        logic [31:0] a, ar;
        logic [3:0]  d;
        int          stalls, w0, exp_stalls;
        bit          done, aborted;
        a = $urandom; ar = $urandom; d = 4'($urandom);
        mem_addr = a; mem_data = $urandom; alu_res = ar; reg_dest = d;
        mem_write_enable = is_store; reg_write_enable = !is_store;
        wb_res_mux = is_store ? 2'b00 : 2'b01;
        next_pc = $urandom; imm = $urandom; dmem_rdata = rd;
        stalls = 0; done = 0; w0 = writes;
        aborted = (lat > TIMEOUT);
        exp_stalls = aborted ? TIMEOUT : lat;
        for (int c = 0; c <= TIMEOUT + 1 && !done; c++) begin
            dmem_ack = (c == lat);
            #1;
            total++;
            if (mem_stall !== ((c != lat) && (c < TIMEOUT)))
                begin bad++; $display("FAIL stall c=%0d got=%b exp=%b", c, mem_stall, (c != lat) && (c < TIMEOUT)); end
            total++;
            if (dmem_req !== 1'b1 || dmem_we !== is_store || dmem_addr !== a)
                begin bad++; $display("FAIL req_stable c=%0d req=%b we=%b addr=%h exp_addr=%h", c, dmem_req, dmem_we, dmem_addr, a); end
            if (mem_stall) stalls++; else done = 1;
            @(posedge clk); #1;
            dmem_ack = 0;
            if (!done) begin
                total++;
                if (out_reg_write_enable !== 1'b0 || out_wb_res_mux !== 2'b00)
                    begin bad++; $display("FAIL bubble c=%0d we=%b mux=%b exp=0", c, out_reg_write_enable, out_wb_res_mux); end
            end
        end
        if (!is_store && !aborted) exp_rdata = rd;
        if (aborted) exp_err = 1'b1;
        total++;
        if (stalls != exp_stalls) begin bad++; $display("FAIL stall_count got=%0d exp=%0d", stalls, exp_stalls); end
        total++;
        if (out_reg_write_enable !== (!is_store && !aborted))
            begin bad++; $display("FAIL wb_we got=%b exp=%b", out_reg_write_enable, !is_store && !aborted); end
        total++;
        if (out_mem_rdata !== exp_rdata) begin bad++; $display("FAIL wb_rdata got=%h exp=%h", out_mem_rdata, exp_rdata); end
        total++;
        if (mem_err !== exp_err) begin bad++; $display("FAIL mem_err got=%b exp=%b", mem_err, exp_err); end
        total++;
        if ((writes - w0) != ((is_store && !aborted) ? 1 : 0))
            begin bad++; $display("FAIL write_count got=%0d exp=%0d", writes - w0, (is_store && !aborted) ? 1 : 0); end
        total++;
        if (out_alu_res !== ar || out_reg_dest !== d)
            begin bad++; $display("FAIL wb_fields alu=%h exp=%h dest=%h exp=%h", out_alu_res, ar, out_reg_dest, d); end
        mem_write_enable = 0; reg_write_enable = 0; wb_res_mux = 0;
    endtask

    task automatic run_alu();
        logic [31:0] ar;
        ar = $urandom; alu_res = ar; reg_write_enable = 1; wb_res_mux = 2'b00;
        mem_write_enable = 0;
        #1;
        total++;
        if (mem_stall !== 1'b0 || dmem_req !== 1'b0)
            begin bad++; $display("FAIL alu_no_access stall=%b req=%b exp=0", mem_stall, dmem_req); end
        @(posedge clk); #1;
        total++;
        if (out_alu_res !== ar || out_reg_write_enable !== 1'b1 || out_mem_rdata !== exp_rdata)
            begin bad++; $display("FAIL alu_wb alu=%h exp=%h we=%b rdata=%h exp=%h", out_alu_res, ar, out_reg_write_enable, out_mem_rdata, exp_rdata); end
        reg_write_enable = 0;
    endtask

    task automatic test_reset();
        rst = 1; clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({out_wb_res_mux, out_reg_write_enable, out_reg_dest, out_alu_res, out_mem_rdata, out_next_pc, out_imm} !== '0
            || mem_err !== 1'b0 || dmem_req !== 1'b0 || mem_stall !== 1'b0)
            begin bad++; $display("FAIL reset_state err=%b req=%b we=%b rdata=%h exp=0", mem_err, dmem_req, out_reg_write_enable, out_mem_rdata); end
        rst = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_load_zero_wait();
        run_access(1'b0, 0, 32'hCAFE0001);
    endtask

    task automatic test_store_wait();
        run_access(1'b1, 3, 32'h0);
    endtask

    task automatic test_branch();
        logic [5:0]  fl [6]  = '{6'b000001, 6'b000001, 6'b110111, 6'b111111, 6'b000000, 6'b001000};
        logic [3:0]  fc [6]  = '{4'd0, 4'd0, 4'd3, 4'd7, 4'd0, 4'd3};
        bit          jf [6]  = '{0, 0, 1, 1, 0, 1};
        bit          sel [6] = '{0, 1, 1, 0, 0, 0};
        bit          exp [6] = '{1, 0, 1, 0, 0, 1};
        for (int i = 0; i < 6; i++) begin
            is_branch = 1; flags = fl[i]; flag_code = fc[i]; sel_jflag_branch = jf[i];
            sel_beq_bne = jf[i] ? 1'b0 : sel[i]; sel_jt_jf = jf[i] ? sel[i] : 1'b0;
            branch_addr = $urandom;
            #1;
            total++;
            if (branch_taken !== exp[i] || branch_target !== branch_addr || mem_stall !== 1'b0)
                begin bad++; $display("FAIL branch_%0d taken=%b exp=%b tgt=%h exp=%h", i, branch_taken, exp[i], branch_target, branch_addr); end
        end
        for (int i = 0; i < 20; i++) begin
            bit c, e;
            is_branch = 1'($urandom); flags = 6'($urandom); flag_code = 4'($urandom);
            sel_jflag_branch = 1'($urandom); sel_beq_bne = 1'($urandom); sel_jt_jf = 1'($urandom);
            if (sel_jflag_branch) c = (flag_code < 6) ? ((flags >> flag_code) & 6'd1) != 0 : 1'b0;
            else c = (flags % 2) == 1;
            e = is_branch && (c != (sel_jflag_branch ? sel_jt_jf : sel_beq_bne));
            #1;
            total++;
            if (branch_taken !== e)
                begin bad++; $display("FAIL branch_rand fl=%b fc=%0d got=%b exp=%b", flags, flag_code, branch_taken, e); end
        end
        is_branch = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_timeout();
        run_access(1'b0, 1000, 32'h12345678);
        #1;
        total++;
        if (dmem_req !== 1'b0 || mem_stall !== 1'b0)
            begin bad++; $display("FAIL idle_after_timeout req=%b stall=%b exp=0", dmem_req, mem_stall); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_wait();
        mem_addr = $urandom; reg_write_enable = 1; wb_res_mux = 2'b01; alu_res = $urandom;
        repeat (2) @(posedge clk);
        #1;
        rst = 1;
        @(posedge clk); #1;
        total++;
        if (dmem_req !== 1'b0 || mem_err !== 1'b0 || out_reg_write_enable !== 1'b0 || out_mem_rdata !== 32'h0
            || out_alu_res !== 32'h0 || out_next_pc !== 32'h0 || out_imm !== 32'h0 || out_reg_dest !== 4'h0)
            begin bad++; $display("FAIL reset_mid_wait req=%b err=%b rdata=%h alu=%h exp=0", dmem_req, mem_err, out_mem_rdata, out_alu_res); end
        clear_inputs();
        rst = 0; exp_err = 0; exp_rdata = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        run_access(1'b0, 1, 32'h0BADF00D);
        run_alu();
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++) begin
            int kind;
            kind = $urandom_range(0, 2);
            if (kind == 2) run_alu();
            else run_access(kind == 1, $urandom_range(0, TIMEOUT + 2), $urandom);
        end
    endtask

    initial begin
        test_reset();
        test_load_zero_wait();
        test_store_wait();
        test_branch();
        test_timeout();
        test_reset_mid_wait();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
